// File: rtl/timer_irq_arbiter.sv
// Timer interrupt arbiter: edge-detects channel and terminal-count interrupts into a
// masked pending register and hands one source at a time to the CPU (req/ack/EOI).
module timer_irq_arbiter #(
    parameter int CHANNELS = 8,
    parameter int ID_W     = $clog2(CHANNELS + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] t_irq,
    input  logic                tc_irq,
    input  logic                mask_we,
    input  logic [CHANNELS:0]   mask_wdata,
    output logic                irq_req,
    output logic [ID_W-1:0]     irq_id,
    input  logic                irq_ack,
    input  logic                irq_eoi,
    output logic [CHANNELS:0]   pending,
    output logic [CHANNELS:0]   mask,
    output logic [CHANNELS:0]   overrun,
    input  logic [CHANNELS:0]   overrun_clr,
    output logic [1:0]          fsm_state
);

    localparam int SRC = CHANNELS + 1;

    // CPU handshake: irq_req stays high with irq_id stable until irq_ack is seen in REQ;
    // the grant then sits in SERVICE until irq_eoi. ack/eoi in any other state are ignored.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SRC-1:0]  src, prev_q, edges, eligible, ack_clr;
    logic [SRC-1:0]  pending_q, mask_q, overrun_q;
    logic [ID_W-1:0] id_q, id_d, rr_q, rr_d, pick;
    logic            pick_valid;
    logic [ID_W:0]   scan_sum;
    logic [ID_W-1:0] scan_idx;

    assign src      = {tc_irq, t_irq};
    assign edges    = src & ~prev_q;
    assign eligible = pending_q & mask_q;

    always_comb begin
        ack_clr = '0;
        if (state_q == REQ && irq_ack) begin
            ack_clr[id_q] = 1'b1;
        end
    end

    // Rotating priority: scan from the highest offset down so the lowest offset from rr_q wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = SRC - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_q} + (ID_W + 1)'(k);
            if (scan_sum >= (ID_W + 1)'(SRC)) begin
                scan_sum = scan_sum - (ID_W + 1)'(SRC);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (eligible[scan_idx]) begin
                pick       = scan_idx;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    id_d    = pick;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    rr_d    = (id_q == ID_W'(SRC - 1)) ? '0 : id_q + 1'b1;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            id_q      <= '0;
            rr_q      <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
            prev_q    <= src;
            // A fresh edge beats an ack clear; an edge on a still-pending source is an overrun.
            pending_q <= (pending_q & ~ack_clr) | edges;
            overrun_q <= (overrun_q & ~overrun_clr) | (edges & pending_q & ~ack_clr);
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    assign irq_req   = (state_q == REQ);
    assign irq_id    = id_q;
    assign pending   = pending_q;
    assign mask      = mask_q;
    assign overrun   = overrun_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_timer_irq_arbiter.sv
// Bench for timer_irq_arbiter: directed vector table, hand sequences for multi-cycle
// corners, then random traffic checked against a behavioural model.
module tb_timer_irq_arbiter;

    localparam int CH  = 8;
    localparam int SRC = CH + 1;
    localparam int IDW = 4;

    logic           CLK, RST;
    logic [CH-1:0]  t_irq;
    logic           tc_irq, mask_we, irq_ack, irq_eoi;
    logic [SRC-1:0] mask_wdata, overrun_clr;
    logic           irq_req;
    logic [IDW-1:0] irq_id;
    logic [SRC-1:0] pending, mask, overrun;
    logic [1:0]     fsm_state;

    int checks = 0;
    int errors = 0;

    timer_irq_arbiter #(.CHANNELS(CH), .ID_W(IDW)) dut (
        .CLK(CLK), .RST(RST), .t_irq(t_irq), .tc_irq(tc_irq),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack), .irq_eoi(irq_eoi),
        .pending(pending), .mask(mask), .overrun(overrun),
        .overrun_clr(overrun_clr), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    bit [SRC-1:0] m_prev, m_pend, m_mask, m_ovr;
    int           m_id, m_rr;
    bit           m_req, m_svc;

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_mask = '0; m_ovr = '0;
        m_id = 0; m_rr = 0; m_req = 0; m_svc = 0;
    endtask

    // Grant goes to the eligible source at the smallest circular distance from the pointer.
    function automatic int model_pick(bit [SRC-1:0] elig, int rr);
        int best = -1;
        int bestd = SRC;
        for (int i = 0; i < SRC; i++) begin
            int d = (i - rr + SRC) % SRC;
            if (elig[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic model_update();
        bit [SRC-1:0] srcv, edg, clr, elig;
        int           p;
        srcv   = {tc_irq, t_irq};
        edg    = srcv & ~m_prev;
        elig   = m_pend & m_mask;
        clr    = '0;
        if (m_req && irq_ack) clr[m_id] = 1'b1;
        m_ovr  = (m_ovr & ~overrun_clr) | (edg & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | edg;
        m_prev = srcv;
        if (!m_req && !m_svc) begin
            p = model_pick(elig, m_rr);
            if (p >= 0) begin
                m_id  = p;
                m_req = 1;
            end
        end else if (m_req && irq_ack) begin
            m_req = 0;
            m_svc = 1;
            m_rr  = (m_id + 1) % SRC;
        end else if (m_svc && irq_eoi) begin
            m_svc = 0;
        end
        if (mask_we) m_mask = mask_wdata;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("irq_req", 32'(irq_req), 32'(m_req));
        check("irq_id", 32'(irq_id), 32'(m_id));
        check("pending", 32'(pending), 32'(m_pend));
        check("mask", 32'(mask), 32'(m_mask));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        t_irq = '0; tc_irq = 0; mask_we = 0; mask_wdata = '0;
        irq_ack = 0; irq_eoi = 0; overrun_clr = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        if (RST) model_reset();
        else     model_update();
        #1;
        compare_model();
    endtask

    task automatic wait_req(input int id);
        int n = 0;
        while (!irq_req && n < 6) begin
            step();
            n++;
        end
        check("wait_req", 32'(irq_req), 32'd1);
        check("grant_id", 32'(irq_id), 32'(id));
    endtask

    task automatic serve();
        irq_ack = 1; step(); irq_ack = 0;
        irq_eoi = 1; step(); irq_eoi = 0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [CH-1:0]  t;
        logic           tc;
        logic           mwe;
        logic [SRC-1:0] mwd;
        logic           ack;
        logic           eoi;
        logic           e_req;
        logic [IDW-1:0] e_id;
        logic [SRC-1:0] e_pend;
        logic [SRC-1:0] e_mask;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{8'h00, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 9'h1FF};
        vecs[1]  = '{8'h08, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 4'd0, 9'h008, 9'h1FF};
        vecs[2]  = '{8'h00, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 4'd3, 9'h008, 9'h1FF};
        vecs[3]  = '{8'h00, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 4'd3, 9'h008, 9'h1FF};
        vecs[4]  = '{8'h00, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 4'd3, 9'h000, 9'h1FF};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 4'd3, 9'h000, 9'h1FF};
        vecs[6]  = '{8'h00, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0, 1'b0, 4'd3, 9'h000, 9'h0FF};
        vecs[7]  = '{8'h00, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 4'd3, 9'h100, 9'h0FF};
        vecs[8]  = '{8'h00, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 4'd3, 9'h100, 9'h0FF};
        vecs[9]  = '{8'h00, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 4'd3, 9'h100, 9'h1FF};
        vecs[10] = '{8'h00, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 4'd8, 9'h100, 9'h1FF};
        vecs[11] = '{8'h00, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 4'd8, 9'h000, 9'h1FF};
        vecs[12] = '{8'h00, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 4'd8, 9'h000, 9'h1FF};
        vecs[13] = '{8'h00, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 4'd8, 9'h000, 9'h1FF};
    end

    // ---------------- test sequence ----------------
    initial begin
        clear_inputs();
        model_reset();
        RST = 1;
        #1;
        check("rst_req", 32'(irq_req), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        step();
        step();
        RST = 0;

        // single edge and mask gating
        for (int i = 0; i < 14; i++) begin
            t_irq = vecs[i].t; tc_irq = vecs[i].tc; mask_we = vecs[i].mwe;
            mask_wdata = vecs[i].mwd; irq_ack = vecs[i].ack; irq_eoi = vecs[i].eoi;
            step();
            check($sformatf("vec%0d_req", i), 32'(irq_req), 32'(vecs[i].e_req));
            check($sformatf("vec%0d_id", i), 32'(irq_id), 32'(vecs[i].e_id));
            check($sformatf("vec%0d_pend", i), 32'(pending), 32'(vecs[i].e_pend));
            check($sformatf("vec%0d_mask", i), 32'(mask), 32'(vecs[i].e_mask));
        end
        clear_inputs();
        step();

        // round robin 1 -> 5 -> 8, then pointer wraps: 1 -> 5
        t_irq = 8'h22; tc_irq = 1; step();
        clear_inputs();
        wait_req(1); serve();
        wait_req(5); serve();
        wait_req(8); serve();
        t_irq = 8'h22; step();
        clear_inputs();
        wait_req(1); serve();
        wait_req(5); serve();

        // overrun and edge coincident with ack
        t_irq = 8'h04; step();
        t_irq = 8'h00;
        wait_req(2);
        t_irq = 8'h04; step();
        check("ovr_set", 32'(overrun[2]), 32'd1);
        t_irq = 8'h00; step();
        overrun_clr = 9'h004; step();
        overrun_clr = '0;
        check("ovr_clr", 32'(overrun[2]), 32'd0);
        t_irq = 8'h04; irq_ack = 1; step();
        clear_inputs();
        check("coinc_pend", 32'(pending[2]), 32'd1);
        check("coinc_ovr", 32'(overrun[2]), 32'd0);
        check("coinc_req", 32'(irq_req), 32'd0);
        irq_eoi = 1; step(); irq_eoi = 0;
        wait_req(2); serve();

        // handshake hold while other sources fire; EOI in REQ ignored
        t_irq = 8'h40; step();
        t_irq = 8'h00;
        wait_req(6);
        for (int i = 0; i < 10; i++) begin
            t_irq = 8'($urandom); tc_irq = 1'($urandom); irq_eoi = 1'($urandom);
            step();
            check("hold_req", 32'(irq_req), 32'd1);
            check("hold_id", 32'(irq_id), 32'd6);
        end
        clear_inputs();
        irq_ack = 1; step(); irq_ack = 0;

        // async reset in SERVICE
        @(negedge CLK);
        #2 RST = 1;
        #1;
        model_reset();
        check("arst_req", 32'(irq_req), 32'd0);
        check("arst_id", 32'(irq_id), 32'd0);
        check("arst_pend", 32'(pending), 32'd0);
        check("arst_mask", 32'(mask), 32'd0);
        check("arst_ovr", 32'(overrun), 32'd0);
        step();
        RST = 0;
        mask_we = 1; mask_wdata = 9'h1FF; step(); mask_we = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_req", 32'(irq_req), 32'd0);
        end

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            t_irq       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            tc_irq      = ($urandom_range(0, 4) == 0);
            mask_we     = ($urandom_range(0, 19) == 0);
            mask_wdata  = ($urandom_range(0, 1) == 0) ? 9'h1FF : 9'($urandom);
            irq_ack     = ($urandom_range(0, 2) == 0);
            irq_eoi     = ($urandom_range(0, 2) == 0);
            overrun_clr = ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'h000;
            step();
        end
        clear_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
